// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: in-order command front-end that drives the RAM cs/we/oe protocol.
// Commands are buffered in a small FIFO; reads return data over a valid/ready port.
module ram_access_ctrl #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int OE_CYCLES  = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              ram_cs,
   output logic              ram_we,
   output logic              ram_oe,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out,
   output logic              busy
);
   localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
   localparam int OE_W    = 4;

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_SEL, S_RD_OE, S_RSP} state_t;

   logic [ENTRY_W-1:0] r_fifo [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wptr, r_rptr;
   logic [CNT_W-1:0]   r_count, w_count_nxt;
   logic               r_req_ready;
   logic               w_push, w_pop, w_empty;
   logic [ENTRY_W-1:0] w_head;
   logic               w_head_write;
   logic [ADDR_W-1:0]  w_head_addr;
   logic [DATA_W-1:0]  w_head_wdata;

   state_t             r_state, w_state_nxt;
   logic [OE_W-1:0]    r_oe_cnt, w_oe_cnt_nxt;
   logic               w_capture;
   logic               r_cs, r_we, r_oe, r_rsp_valid;
   logic [ADDR_W-1:0]  r_ram_addr, r_rsp_addr;
   logic [DATA_W-1:0]  r_ram_din, r_rsp_rdata;

   // ---------------- command FIFO ----------------
   // req_ready comes only from registered occupancy, so a pop never frees a slot
   // for a push in the same cycle.
   assign w_push       = req_valid && r_req_ready;
   assign w_empty      = (r_count == '0);
   assign w_head       = r_fifo[r_rptr];
   assign w_head_write = w_head[ENTRY_W-1];
   assign w_head_addr  = w_head[DATA_W +: ADDR_W];
   assign w_head_wdata = w_head[DATA_W-1:0];

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + CNT_W'(1);
      else if (!w_push && w_pop)
         w_count_nxt = r_count - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_fifo[r_wptr] <= {req_write, req_addr, req_wdata};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_req_ready <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_W'(1);
         if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
         r_count     <= w_count_nxt;
         r_req_ready <= (w_count_nxt != CNT_W'(FIFO_DEPTH));
      end
   end

   // ---------------- sequencing FSM ----------------
   always_comb begin
      w_state_nxt  = r_state;
      w_oe_cnt_nxt = r_oe_cnt;
      w_pop        = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = w_head_write ? S_WR : S_RD_SEL;
            end
         end
         S_WR:     w_state_nxt = S_IDLE;
         S_RD_SEL: begin
            w_state_nxt  = S_RD_OE;
            w_oe_cnt_nxt = OE_W'(OE_CYCLES - 1);
         end
         S_RD_OE: begin
            if (r_oe_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = S_RSP;
            end else begin
               w_oe_cnt_nxt = r_oe_cnt - OE_W'(1);
            end
         end
         S_RSP: begin
            if (rsp_ready)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Controls are registered from the next state so the RAM pins never glitch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_oe_cnt    <= '0;
         r_cs        <= 1'b0;
         r_we        <= 1'b0;
         r_oe        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_din   <= '0;
         r_rsp_addr  <= '0;
         r_rsp_rdata <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_oe_cnt    <= w_oe_cnt_nxt;
         r_cs        <= (w_state_nxt == S_WR) || (w_state_nxt == S_RD_SEL) ||
                        (w_state_nxt == S_RD_OE);
         r_we        <= (w_state_nxt == S_WR);
         r_oe        <= (w_state_nxt == S_RD_OE);
         r_rsp_valid <= (w_state_nxt == S_RSP);
         if (w_pop) begin
            r_ram_addr <= w_head_addr;
            r_ram_din  <= w_head_wdata;
         end
         if (w_capture) begin
            r_rsp_rdata <= ram_data_out;
            r_rsp_addr  <= r_ram_addr;
         end
      end
   end

   assign req_ready   = r_req_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_addr    = r_rsp_addr;
   assign ram_cs      = r_cs;
   assign ram_we      = r_we;
   assign ram_oe      = r_oe;
   assign ram_address = r_ram_addr;
   assign ram_data_in = r_ram_din;
   assign busy        = (r_state != S_IDLE) || !w_empty;

endmodule
